svm_entry_sequencer: RTL

Initiator-side front end for the `SVM` classifier.
- Accepts one entry per upstream handshake, carrying both the valence and the arousal feature vectors.
- Drives them to the SVM `fin` port as two back-to-back transactions: valence first, then arousal.
- Collects the paired `valence`/`arousal` labels from the SVM `dout` port and returns them downstream, tagged with an entry ID and a measured latency.
- Sits between the feature-extraction front end and `SVM` in the emotion-classification datapath.

---
 rtl/svm_entry_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/svm_entry_sequencer.sv
// Front end for the SVM classifier: splits each entry into valence/arousal fin beats and
// returns tagged, latency-stamped labels. Define SVM_SEQ_LATENCY_EN to build the latency counter.
module svm_entry_sequencer #(
   parameter int NBITS     = 16,
   parameter int F_WIDTH   = 20,
   parameter int TAG_WIDTH = 8,
   parameter int LAT_WIDTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NBITS*F_WIDTH-1:0]   ein_v_features,
   input  logic [NBITS*F_WIDTH-1:0]   ein_a_features,
   input  logic                       ein_valid,
   output logic                       ein_ready,
   output logic [NBITS*F_WIDTH-1:0]   in_features,
   output logic                       fin_valid,
   input  logic                       fin_ready,
   input  logic                       valence,
   input  logic                       arousal,
   input  logic                       dout_valid,
   output logic                       dout_ready,
   output logic                       res_valence,
   output logic                       res_arousal,
   output logic [TAG_WIDTH-1:0]       res_tag,
   output logic [LAT_WIDTH-1:0]       res_latency,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       err_orphan
);
   localparam int VW = NBITS*F_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND_V, SEND_A} state_t;
   state_t state, state_nx;

   logic [VW-1:0]        a_vec;
   logic [TAG_WIDTH-1:0] tag_ctr, cur_tag;
   logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic [LAT_WIDTH-1:0] lat_nx;
   logic                 ein_fire, v_fire, a_fire, pop;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      ein_ready = 1'b0;
      fin_valid = 1'b0;
      case (state)
         IDLE: begin
            ein_ready = (count < DEPTH_C);
            if (ein_valid && ein_ready) state_nx = SEND_V;
         end
         SEND_V: begin
            fin_valid = 1'b1;
            if (fin_ready) state_nx = SEND_A;
         end
         SEND_A: begin
            fin_valid = 1'b1;
            if (fin_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign ein_fire   = ein_valid && ein_ready;
   assign v_fire     = (state == SEND_V) && fin_ready;
   assign a_fire     = (state == SEND_A) && fin_ready;
   // Only accept a new label when the output register is free or draining this cycle.
   assign dout_ready = (count != '0) && (!res_valid || res_ready);
   assign pop        = dout_valid && dout_ready;

`ifdef SVM_SEQ_LATENCY_EN
   logic [LAT_WIDTH-1:0] cyc, t_start;
   logic [LAT_WIDTH-1:0] ts_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc     <= '0;
         t_start <= '0;
      end else begin
         cyc <= cyc + LAT_WIDTH'(1);
         if (v_fire) t_start <= cyc;
      end
   end

   always_ff @(posedge clk) begin
      if (a_fire) ts_mem[wr_ptr] <= t_start;
   end

   assign lat_nx = cyc - ts_mem[rd_ptr];
`else
   assign lat_nx = '0;
`endif

   always_ff @(posedge clk) begin
      if (a_fire) tag_mem[wr_ptr] <= cur_tag;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_ctr     <= '0;
         cur_tag     <= '0;
         in_features <= '0;
         a_vec       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         res_valid   <= 1'b0;
         res_valence <= 1'b0;
         res_arousal <= 1'b0;
         res_tag     <= '0;
         res_latency <= '0;
         err_orphan  <= 1'b0;
      end else begin
         // The valence vector goes straight to the output; arousal waits for its beat.
         if (ein_fire) begin
            in_features <= ein_v_features;
            a_vec       <= ein_a_features;
            cur_tag     <= tag_ctr;
            tag_ctr     <= tag_ctr + TAG_WIDTH'(1);
         end
         if (v_fire) in_features <= a_vec;
         if (a_fire) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         case ({a_fire, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (pop) begin
            res_valid   <= 1'b1;
            res_valence <= valence;
            res_arousal <= arousal;
            res_tag     <= tag_mem[rd_ptr];
            res_latency <= lat_nx;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
         if (dout_valid && (count == '0)) err_orphan <= 1'b1;
      end
   end
endmodule
